// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 6;
    localparam int unsigned MD_ITERS = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_addsub.sv
// Add/subtract shared by the Booth step, the divide trial subtract and sign negation.
module multdiv_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum_c
);

    assign sum_c = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, 33 edges from start to result.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned SW = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_ITERS);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] q, q_next;
    logic [WIDTH-1:0] m, m_next;
    logic             qm1, qm1_next;
    logic             neg, neg_next;
    logic             dz, dz_next;
    logic [WIDTH-1:0] result_next;
    logic             exc_next, rdy_next, busy_next;

    logic [SW-1:0]    as_a, as_b, as_sum, booth;
    logic             as_sub;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    multdiv_addsub #(.W(SW)) u_addsub (
        .a     (as_a),
        .b     (as_b),
        .sub   (as_sub),
        .sum_c (as_sum)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            q              <= '0;
            m              <= '0;
            qm1            <= 1'b0;
            neg            <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            acc            <= acc_next;
            q              <= q_next;
            m              <= m_next;
            qm1            <= qm1_next;
            neg            <= neg_next;
            dz             <= dz_next;
            data_result    <= result_next;
            data_exception <= exc_next;
            data_resultRDY <= rdy_next;
            busy           <= busy_next;
        end
    end

    // Next-state, iteration step and finalisation
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        acc_next    = acc;
        q_next      = q;
        m_next      = m;
        qm1_next    = qm1;
        neg_next    = neg;
        dz_next     = dz;
        result_next = data_result;
        exc_next    = data_exception;
        rdy_next    = 1'b0;
        busy_next   = busy;
        as_a        = '0;
        as_b        = '0;
        as_sub      = 1'b0;
        booth       = '0;

        case (state)
            MUL_RUN: begin
                // q[0]=1,q-1=0 subtracts; q[0]=0,q-1=1 adds; equal bits keep acc
                as_a   = {acc[WIDTH-1], acc};
                as_b   = {m[WIDTH-1], m};
                as_sub = q[0];
                if (cnt == LAST) begin
                    result_next = q;
                    exc_next    = (acc != {WIDTH{q[WIDTH-1]}});
                    rdy_next    = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    booth    = (q[0] ^ qm1) ? as_sum : {acc[WIDTH-1], acc};
                    acc_next = booth[SW-1:1];
                    q_next   = {booth[0], q[WIDTH-1:1]};
                    qm1_next = q[0];
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DIV_RUN: begin
                as_sub = 1'b1;
                if (cnt == LAST) begin
                    as_b = {1'b0, q};
                    if (dz) begin
                        result_next = '0;
                        exc_next    = 1'b1;
                    end else begin
                        result_next = neg ? as_sum[WIDTH-1:0] : q;
                        exc_next    = ~neg & q[WIDTH-1];
                    end
                    rdy_next   = 1'b1;
                    busy_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    as_a = {acc, q[WIDTH-1]};
                    as_b = {1'b0, m};
                    if (!as_sum[SW-1]) begin
                        acc_next = as_sum[WIDTH-1:0];
                        q_next   = {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_next = as_a[WIDTH-1:0];
                        q_next   = {q[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // A lone start pulse aborts anything in flight; both pulses together are ignored
        if (ctrl_MULT ^ ctrl_DIV) begin
            state_next = ctrl_MULT ? MUL_RUN : DIV_RUN;
            cnt_next   = '0;
            acc_next   = '0;
            qm1_next   = 1'b0;
            busy_next  = 1'b1;
            rdy_next   = 1'b0;
            neg_next   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_next    = (data_operandB == '0);
            if (ctrl_MULT) begin
                m_next = data_operandA;
                q_next = data_operandB;
            end else begin
                m_next = mag_b;
                q_next = mag_a;
            end
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: vector table plus abort, illegal-start and reset sequences.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        string       name;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start one operation, scramble operands after E0, check timing, result and hold.
    task automatic run_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string name);
        logic bad;
        logic [31:0] bad_cyc;
        @(negedge clock);
        ctrl_MULT = mul;
        ctrl_DIV  = ~mul;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check({name, " busy@E0"}, {31'b0, busy}, 32'd1);
        bad = 1'b0;
        bad_cyc = 32'd0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            if (!bad && (data_resultRDY !== 1'b0 || busy !== 1'b1)) begin
                bad = 1'b1;
                bad_cyc = 32'(k);
            end
        end
        check({name, " early_rdy_or_busy_drop_edge"}, bad_cyc, 32'd0);
        @(negedge clock);
        check({name, " rdy@E33"}, {31'b0, data_resultRDY}, 32'd1);
        check({name, " busy@E33"}, {31'b0, busy}, 32'd0);
        check({name, " result"}, data_result, er);
        check({name, " exception"}, {31'b0, data_exception}, {31'b0, ee});
        @(negedge clock);
        check({name, " rdy@E34"}, {31'b0, data_resultRDY}, 32'd0);
        check({name, " hold"}, data_result, er);
    endtask

    initial begin
        int rdy_cnt;
        int rdy_at;
        logic [31:0] res_at;
        logic saw_busy;
        logic [31:0] prev;

        vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3"};
        vecs[1]  = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf"};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, "mul_min_x1"};
        vecs[3]  = '{1'b1, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0, "mul_6x7"};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_-1x-1"};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_x-1"};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div_-7/2"};
        vecs[7]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7/-2"};
        vecs[8]  = '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, "div_100/7"};
        vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, "div_by_zero"};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min/-1"};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, "div_min/1"};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0, "div_min/2"};
        vecs[13] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 1'b0, "div_-1/7"};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'b0, data_exception}, 32'd0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].mul, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].name);

        // Abort: MULT 3x4 at E0, DIV 20/5 sampled at E10
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        rdy_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        rdy_at = 0;
        res_at = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                rdy_at = k;
                res_at = data_result;
            end
        end
        check("abort rdy_count", 32'(rdy_cnt), 32'd1);
        check("abort rdy_edge", 32'(rdy_at), 32'd33);
        check("abort result", res_at, 32'd4);

        // Illegal: both starts together
        prev = data_result;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        saw_busy = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            if (data_resultRDY === 1'b1) rdy_cnt++;
            @(negedge clock);
        end
        check("illegal busy", {31'b0, saw_busy}, 32'd0);
        check("illegal rdy_count", 32'(rdy_cnt), 32'd0);
        check("illegal result_hold", data_result, prev);

        // Reset mid-run: MULT 3x4 at E0, reset sampled at E5
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset rdy", {31'b0, data_resultRDY}, 32'd0);
        check("midreset result", data_result, 32'd0);
        check("midreset exception", {31'b0, data_exception}, 32'd0);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_cnt++;
        end
        check("midreset no_activity", 32'(rdy_cnt), 32'd0);

        run_op(1'b1, 32'd6, 32'd7, 32'd42, 1'b0, "post_reset_6x7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv.md
Name: multdiv

Overview:
Iterative signed 32-bit multiply/divide unit in the execute stage, alongside the combinational alu. It receives the same operand buses from decode/bypass. The processor stalls until data_resultRDY, then muxes data_result into the X/M latch in place of the alu result. data_exception drives the $rstatus write path in the same way alu overflow does.

Parameters:
WIDTH, 32, operand/result width; only 32 is verified.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state on the posedge where sampled high
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  single-cycle start pulse for multiply
ctrl_DIV  input  1  single-cycle start pulse for divide
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  multiply overflow, divide-by-zero, or divide overflow
data_resultRDY  output  1  one-cycle pulse: result/exception valid
busy  output  1  high while an operation is in progress

Behaviour:
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE: no operation.
  - MUL_RUN: 32 iterations of radix-2 Booth (add/sub/none on a 65-bit {acc,Q,q-1}, then arithmetic shift right 1).
  - DIV_RUN: 32 iterations of restoring division on operand magnitudes.
  - DONE: holds results.
- Start: sampled at posedge E0 when exactly one of ctrl_MULT/ctrl_DIV is high. Operands are latched at E0, so later operand changes have no effect. The unit enters MUL_RUN/DIV_RUN, sets busy=1, and sets counter=0.
- Both ctrl_MULT and ctrl_DIV high at the same edge: illegal; no start, and current state is unchanged.
- Start accepted in any state, including mid-run: the current operation is aborted silently (no RDY) and restarts with the new operands.
- Latency:
  - Iteration edges are E1..E32.
  - At E33: data_result and data_exception are updated, data_resultRDY=1, busy=0, state=DONE.
  - At E34: data_resultRDY=0. State stays DONE (IDLE-equivalent); data_result and data_exception hold until the next start or reset.
- Multiply: signed × signed. data_result = product[31:0]. data_exception=1 iff product[63:32] differs from the sign-extension of product[31].
- Divide: quotient truncated toward zero. Quotient sign = A[31]^B[31]; the remainder is discarded. Sign correction (negate) is applied at E33.
  - B==0: data_result=0, data_exception=1, still after full latency.
  - A==0x80000000 and B==0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - Magnitude of 0x80000000 is handled as unsigned 2^31; no loss.
- Reset high at any edge overrides start and aborts; all outputs return to reset values on that edge.
- busy is high exactly for edges E0+ .. E32+ (33 cycles).

Decomposition:
- Shared include (multdiv_defs): state encodings (IDLE, MUL_RUN, DIV_RUN, DONE), WIDTH/CNT_W defaults, iteration count 32, and the constant INT_MIN=0x80000000.
- One sub-module, multdiv_addsub: 33-bit add/subtract (sub input selects B inversion plus carry-in). It is shared by the Booth step, the restoring-divide trial subtract, and final sign negation.
- FSM, counter and shift registers live in multdiv.

Test Plan:
1. MULT A=7, B=0xFFFFFFFD (−3) -> data_result=0xFFFFFFEB, exception=0; RDY high only in the cycle after E33; busy low from E33.
2. MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. MULT A=0x80000000, B=1 -> 0x80000000, exception=0.
3. DIV A=0xFFFFFFF9 (−7), B=2 -> 0xFFFFFFFD (−3). DIV A=7, B=0xFFFFFFFE -> 0xFFFFFFFD. DIV A=100, B=7 -> 14. All with exception=0.
4. DIV A=5, B=0 -> data_result=0, exception=1 after 33 edges. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception=1.
5. Abort and illegal start:
   - MULT 3×4 started, then DIV 20/5 pulsed at E10 -> no RDY for the MULT; a single RDY with data_result=4 appears 33 edges after the DIV start.
   - Both ctrl_MULT and ctrl_DIV high together -> busy stays 0 and no RDY.
6. Reset: MULT 3×4 started, reset high at E5 -> busy=0, RDY never asserts, outputs 0. A following MULT 6×7 -> 42 with normal latency.
